// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: fixed priority to port 0, starvation relief and bounded lock for port 1.
// Define DMEM_ARB_ACCESS_CHECK_EN to fault misaligned or out-of-range accesses (err_o).
module dmem_arbiter #(
    parameter int unsigned MEM_SIZE     = 1024,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_LOCK     = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [1:0]  lock_i,
    input  logic [1:0]  we_i,
    input  logic [2:0]  mask0_i,
    input  logic [2:0]  mask1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_wen_o,
    output logic [2:0]  mem_mask_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_P0   = 2'b01;
    localparam logic [1:0] OWN_P1   = 2'b10;

    logic [1:0]  owner_q, owner_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d, cnt_inc;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [1:0]  lockout_q, lockout_d;
    logic [1:0]  handoff_q, handoff_d;
    logic [1:0]  rvalid_q;
    logic [31:0] rdata_q;

    logic [1:0]  own_eff;
    logic [1:0]  gnt;
    logic        g_any;
    logic        starved;
    logic        expire;

    logic        w_we;
    logic [2:0]  w_mask;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        is_byte, is_half;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        fault;

    // owner is one-hot, so a dropped request clears ownership this cycle
    assign own_eff = owner_q & req_i;
    assign starved = req_i[1] && (starve_cnt_q == 4'(STARVE_LIMIT));

    always_comb begin
        gnt = 2'b00;
        if (!rst_ni)
            gnt = 2'b00;
        else if (|own_eff)
            gnt = own_eff;
        else if (|(handoff_q & req_i))
            gnt = handoff_q & req_i;
        else if (starved)
            gnt = 2'b10;
        else if (req_i[0])
            gnt = 2'b01;
        else if (req_i[1])
            gnt = 2'b10;
    end

    assign g_any   = |gnt;
    assign w_we    = gnt[1] ? we_i[1]  : we_i[0];
    assign w_mask  = gnt[1] ? mask1_i  : mask0_i;
    assign w_addr  = gnt[1] ? addr1_i  : addr0_i;
    assign w_wdata = gnt[1] ? wdata1_i : wdata0_i;

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        unique case (w_mask)
            3'b001, 3'b101: is_half = 1'b1;
            3'b010, 3'b110: is_byte = 1'b1;
            default: ;
        endcase
    end

    // memory returns the aligned word; lane select and extension happen here
    always_comb begin
        ld_byte = 8'h00;
        unique case (w_addr[1:0])
            2'd0: ld_byte = mem_rdata_i[7:0];
            2'd1: ld_byte = mem_rdata_i[15:8];
            2'd2: ld_byte = mem_rdata_i[23:16];
            2'd3: ld_byte = mem_rdata_i[31:24];
            default: ;
        endcase
    end

    assign ld_half = w_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        ld_data = mem_rdata_i;
        if (is_byte)
            ld_data = {{24{w_mask[2] & ld_byte[7]}}, ld_byte};
        else if (is_half)
            ld_data = {{16{w_mask[2] & ld_half[15]}}, ld_half};
    end

`ifdef DMEM_ARB_ACCESS_CHECK_EN
    logic [32:0] acc_end;
    logic        misalign;
    logic        err_q;

    always_comb begin
        acc_end  = {1'b0, w_addr} + (is_byte ? 33'd1 : is_half ? 33'd2 : 33'd4);
        misalign = (is_half && w_addr[0]) ||
                   (!is_half && !is_byte && (w_addr[1:0] != 2'b00));
        fault    = g_any && (misalign || (acc_end > 33'(MEM_SIZE)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            err_q <= 1'b0;
        else
            err_q <= fault;
    end

    assign err_o = err_q;
`else
    assign fault = 1'b0;
    assign err_o = 1'b0;
`endif

    assign gnt_o       = gnt;
    assign mem_wen_o   = g_any & w_we & ~fault;
    assign mem_mask_o  = g_any ? w_mask  : 3'b000;
    assign mem_addr_o  = g_any ? w_addr  : 32'h0;
    assign mem_wdata_o = g_any ? w_wdata : 32'h0;

    assign cnt_inc = lock_cnt_q + 4'd1;

    always_comb begin
        owner_d    = (|own_eff) ? owner_q : OWN_NONE;
        lock_cnt_d = (|own_eff) ? lock_cnt_q : 4'd0;
        lockout_d  = lockout_q & req_i;
        handoff_d  = 2'b00;
        expire     = 1'b0;
        if (|(gnt & own_eff)) begin
            if (!(|(gnt & lock_i))) begin
                owner_d    = OWN_NONE;
                lock_cnt_d = 4'd0;
            end else if (cnt_inc == 4'(MAX_LOCK)) begin
                expire = 1'b1;
            end else begin
                lock_cnt_d = cnt_inc;
            end
        end else if (|(gnt & lock_i & ~lockout_q)) begin
            if (MAX_LOCK == 1) begin
                expire = 1'b1;
            end else begin
                owner_d    = gnt[1] ? OWN_P1 : OWN_P0;
                lock_cnt_d = 4'd1;
            end
        end
        // expired owner yields one cycle to the other port and cannot relock
        if (expire) begin
            owner_d    = OWN_NONE;
            lock_cnt_d = 4'd0;
            lockout_d  = lockout_d | gnt;
            handoff_d  = {gnt[0], gnt[1]};
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt[1])
            starve_cnt_d = 4'd0;
        else if (req_i[1] && (starve_cnt_q != 4'(STARVE_LIMIT)))
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q      <= OWN_NONE;
            lock_cnt_q   <= 4'd0;
            starve_cnt_q <= 4'd0;
            lockout_q    <= 2'b00;
            handoff_q    <= 2'b00;
            rvalid_q     <= 2'b00;
            rdata_q      <= 32'h0;
        end else begin
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            lockout_q    <= lockout_d;
            handoff_q    <= handoff_d;
            rvalid_q     <= gnt;
            if (g_any)
                rdata_q <= (w_we || fault) ? 32'h0 : ld_data;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic
// against a rule-level reference model and a byte-array memory.
module tb_dmem_arbiter;

    localparam int MEM_SIZE     = 1024;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_LOCK     = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  req_i, lock_i, we_i;
    logic [2:0]  mask0_i, mask1_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_wen_o;
    logic [2:0]  mem_mask_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    dmem_arbiter #(
        .MEM_SIZE(MEM_SIZE), .STARVE_LIMIT(STARVE_LIMIT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i),
        .we_i(we_i), .mask0_i(mask0_i), .mask1_i(mask1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i),
        .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .mem_wen_o(mem_wen_o), .mem_mask_o(mem_mask_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sz_of(input logic [2:0] m);
        if (m == 3'b010 || m == 3'b110) return 1;
        if (m == 3'b001 || m == 3'b101) return 2;
        return 4;
    endfunction

    // memory device: byte array, returns aligned word, writes lanes by mask
    logic [7:0] dev_mem [MEM_SIZE];
    logic [9:0] dev_base;
    always_comb begin
        dev_base    = {mem_addr_o[9:2], 2'b00};
        mem_rdata_i = {dev_mem[dev_base + 10'd3], dev_mem[dev_base + 10'd2],
                       dev_mem[dev_base + 10'd1], dev_mem[dev_base]};
    end

    always @(posedge clk_i) begin
        if (mem_wen_o) begin
            automatic logic [9:0] a = mem_addr_o[9:0];
            automatic int s = sz_of(mem_mask_o);
            if (s == 1) dev_mem[a] <= mem_wdata_o[7:0];
            else if (s == 2) begin
                a[0] = 1'b0;
                dev_mem[a] <= mem_wdata_o[7:0];
                dev_mem[a + 10'd1] <= mem_wdata_o[15:8];
            end else begin
                a[1:0] = 2'b00;
                for (int i = 0; i < 4; i++) dev_mem[a + 10'(i)] <= mem_wdata_o[8*i +: 8];
            end
        end
    end

    // reference model
    logic [7:0] ref_mem [MEM_SIZE];
    int m_owner, m_held, m_wait, m_handoff, m_last;
    bit [1:0] m_banned;

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_wait = 0; m_handoff = -1; m_banned = 2'b00;
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] m, input logic [31:0] ad);
        logic [9:0] a = ad[9:0];
        logic [31:0] v;
        int s = sz_of(m);
        v = 32'h0;
        if (s == 1) begin
            v[7:0] = ref_mem[a];
            if (m[2]) v = {{24{v[7]}}, v[7:0]};
        end else if (s == 2) begin
            a[0] = 1'b0;
            v[15:0] = {ref_mem[a + 10'd1], ref_mem[a]};
            if (m[2]) v = {{16{v[15]}}, v[15:0]};
        end else begin
            a[1:0] = 2'b00;
            for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[a + 10'(i)];
        end
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] m, input logic [31:0] ad, input logic [31:0] d);
        logic [9:0] a = ad[9:0];
        int s = sz_of(m);
        if (s == 4) a[1:0] = 2'b00;
        else if (s == 2) a[0] = 1'b0;
        for (int i = 0; i < s; i++) ref_mem[a + 10'(i)] = d[8*i +: 8];
    endtask

    function automatic bit fault_of(input logic [2:0] m, input logic [31:0] a);
`ifdef DMEM_ARB_ACCESS_CHECK_EN
        int s = sz_of(m);
        if (s == 2 && a[0]) return 1'b1;
        if (s == 4 && a[1:0] != 2'b00) return 1'b1;
        return (longint'(a) + longint'(s)) > longint'(MEM_SIZE);
`else
        return (m === 3'bxxx) && (a === 32'hx);
`endif
    endfunction

    function automatic int pick(input logic [1:0] r);
        if (m_owner >= 0 && r[m_owner]) return m_owner;
        if (m_handoff >= 0 && r[m_handoff]) return m_handoff;
        if (r[1] && m_wait == STARVE_LIMIT) return 1;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    task automatic expire(input int w);
        m_owner = -1; m_held = 0; m_banned[w] = 1'b1; m_handoff = 1 - w;
    endtask

    task automatic model_update(input int w, input logic [1:0] r, input logic [1:0] l);
        if (m_owner >= 0 && !r[m_owner]) begin m_owner = -1; m_held = 0; end
        m_handoff = -1;
        for (int p = 0; p < 2; p++) if (!r[p]) m_banned[p] = 1'b0;
        if (w >= 0) begin
            if (m_owner == w) begin
                m_held++;
                if (!l[w]) begin m_owner = -1; m_held = 0; end
                else if (m_held == MAX_LOCK) expire(w);
            end else if (l[w] && !m_banned[w]) begin
                m_held = 1;
                if (MAX_LOCK == 1) expire(w); else m_owner = w;
            end
        end
        if (w == 1) m_wait = 0;
        else if (r[1] && m_wait < STARVE_LIMIT) m_wait++;
    endtask

    typedef struct {
        logic [1:0] gnt; logic wen; logic [2:0] mask; logic [31:0] addr; logic [31:0] wdata;
    } gexp_t;
    typedef struct {
        int due; logic [1:0] port; logic [31:0] rdata; logic err;
    } rexp_t;
    gexp_t gnt_q[$];
    rexp_t rsp_q[$];

    // one clock cycle of stimulus; expectations pushed for the monitor
    task automatic step(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                        input logic [2:0] m0, input logic [2:0] m1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        gexp_t g;
        rexp_t e;
        int win;
        @(posedge clk_i); #1;
        req_i = r; lock_i = l; we_i = w; mask0_i = m0; mask1_i = m1;
        addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
        win = pick(r);
        m_last = win;
        g = '{gnt: 2'b00, wen: 1'b0, mask: 3'b000, addr: 32'h0, wdata: 32'h0};
        if (win >= 0) begin
            logic [2:0] m = (win == 1) ? m1 : m0;
            logic [31:0] a = (win == 1) ? a1 : a0;
            logic [31:0] d = (win == 1) ? d1 : d0;
            bit f = fault_of(m, a);
            g.gnt = 2'(1 << win); g.mask = m; g.addr = a; g.wdata = d;
            g.wen = w[win] && !f;
            e.due = cyc + 1; e.port = g.gnt; e.err = f;
            e.rdata = (w[win] || f) ? 32'h0 : ref_load(m, a);
            if (g.wen) ref_store(m, a, d);
            rsp_q.push_back(e);
        end
        gnt_q.push_back(g);
        model_update(win, r, l);
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 2'b00, 3'b0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic inputs_idle();
        req_i = 2'b00; lock_i = 2'b00; we_i = 2'b00; mask0_i = 3'b0; mask1_i = 3'b0;
        addr0_i = 32'h0; addr1_i = 32'h0; wdata0_i = 32'h0; wdata1_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk_i); #2;
        inputs_idle();
        rst_ni = 1'b0;
        gnt_q.delete(); rsp_q.delete();
        model_reset();
        @(negedge clk_i); #2;
        rst_ni = 1'b1;
    endtask

    initial begin : monitor
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk_i);
            if (gnt_q.size() > 0) begin
                g = gnt_q.pop_front();
                check("gnt", 32'(gnt_o), 32'(g.gnt));
                check("mem_wen", 32'(mem_wen_o), 32'(g.wen));
                check("mem_mask", 32'(mem_mask_o), 32'(g.mask));
                check("mem_addr", mem_addr_o, g.addr);
                check("mem_wdata", mem_wdata_o, g.wdata);
            end
            if (rvalid_o != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    check("rvalid_spurious", 32'(rvalid_o), 32'h0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_cycle", cyc, r.due);
                    check("rvalid", 32'(rvalid_o), 32'(r.port));
                    check("rdata", rdata_o, r.rdata);
                    check("err", 32'(err_o), 32'(r.err));
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                check("rvalid_missing", 32'(rvalid_o), 32'(r.port));
            end
        end
    end

    logic [1:0]  p_req, p_lock, p_we;
    logic [2:0]  p_mask [2];
    logic [31:0] p_addr [2], p_data [2];
    logic [2:0]  mask_tab [5];

    initial begin : main
        mask_tab = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110};
        for (int i = 0; i < MEM_SIZE; i++) begin dev_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        inputs_idle();
        model_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_wen", 32'(mem_wen_o), 32'h0);
        check("rst_addr", mem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // store then load back on port 0
        step(2'b01, 2'b00, 2'b01, 3'b000, 3'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
        step(2'b01, 2'b00, 2'b00, 3'b000, 3'b0, 32'h10, 32'h0, 32'h0, 32'h0);
        idle(); #2;
        check("t1_rvalid", 32'(rvalid_o), 32'h1);
        check("t1_rdata", rdata_o, 32'hDEADBEEF);

        // starvation relief
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 32'h40, 32'h80, 32'h0, 32'h0);
            #2;
            check($sformatf("t2_gnt%0d", i), 32'(gnt_o), (i % 5 == 4) ? 32'h2 : 32'h1);
        end

        // bounded lock on port 1, no relock until re-request
        do_reset();
        step(2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 32'h40, 32'h80, 32'h0, 32'h0);
        #2;
        check("t3_gnt0", 32'(gnt_o), 32'h2);
        for (int i = 1; i < 14; i++) begin
            step(2'b11, 2'b10, 2'b00, 3'b000, 3'b000, 32'h40, 32'h80, 32'h0, 32'h0);
            #2;
            check($sformatf("t3_gnt%0d", i), 32'(gnt_o),
                  (i < 8 || i == 12) ? 32'h2 : 32'h1);
        end

        // signed and unsigned byte loads
        do_reset();
        step(2'b01, 2'b00, 2'b01, 3'b010, 3'b0, 32'h20, 32'h0, 32'h00000080, 32'h0);
        step(2'b01, 2'b00, 2'b00, 3'b110, 3'b0, 32'h20, 32'h0, 32'h0, 32'h0);
        step(2'b01, 2'b00, 2'b00, 3'b010, 3'b0, 32'h20, 32'h0, 32'h0, 32'h0);
        #2;
        check("t4_lb", rdata_o, 32'hFFFFFF80);
        idle(); #2;
        check("t4_lbu", rdata_o, 32'h00000080);

        // reset during the cycle after a load grant
        do_reset();
        step(2'b01, 2'b00, 2'b00, 3'b000, 3'b0, 32'h10, 32'h0, 32'h0, 32'h0);
        @(negedge clk_i); #2;
        rst_ni = 1'b0;
        gnt_q.delete(); rsp_q.delete();
        model_reset();
        @(posedge clk_i); #1;
        check("t5_rvalid", 32'(rvalid_o), 32'h0);
        check("t5_gnt", 32'(gnt_o), 32'h0);
        check("t5_rdata", rdata_o, 32'h0);
        check("t5_wen", 32'(mem_wen_o), 32'h0);
        check("t5_addr", mem_addr_o, 32'h0);
        inputs_idle();
        @(negedge clk_i); #2;
        rst_ni = 1'b1;

        // misaligned word store
        step(2'b01, 2'b00, 2'b01, 3'b000, 3'b0, 32'h12, 32'h0, 32'h12345678, 32'h0);
        idle(); #2;
`ifdef DMEM_ARB_ACCESS_CHECK_EN
        check("t6_err", 32'(err_o), 32'h1);
`else
        check("t6_err", 32'(err_o), 32'h0);
`endif
        check("t6_rdata", rdata_o, 32'h0);
        step(2'b01, 2'b00, 2'b00, 3'b000, 3'b0, 32'h10, 32'h0, 32'h0, 32'h0);
        idle(); #2;
`ifdef DMEM_ARB_ACCESS_CHECK_EN
        check("t6_mem", rdata_o, 32'hDEADBEEF);
`else
        check("t6_mem", rdata_o, 32'h12345678);
`endif

        // random traffic; requests held until the model grants them
        do_reset();
        p_req = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && $urandom_range(0, 99) < 60) begin
                    automatic int s;
                    automatic int k = $urandom_range(0, 99);
                    p_req[p]  = 1'b1;
                    p_we[p]   = 1'($urandom_range(0, 1));
                    p_lock[p] = ($urandom_range(0, 99) < 30);
                    p_mask[p] = mask_tab[$urandom_range(0, 4)];
                    p_data[p] = $urandom;
                    s = sz_of(p_mask[p]);
                    if (k < 5)
                        p_addr[p] = 32'($urandom_range(MEM_SIZE - 4, MEM_SIZE + 4));
                    else if (k < 15)
                        p_addr[p] = 32'($urandom_range(0, MEM_SIZE - 1));
                    else
                        p_addr[p] = 32'($urandom_range(0, MEM_SIZE - 1)) & ~32'(s - 1);
                end
            end
            step(p_req, p_lock & p_req, p_we & p_req, p_mask[0], p_mask[1],
                 p_addr[0], p_addr[1], p_data[0], p_data[1]);
            if (m_last >= 0) p_req[m_last] = 1'b0;
        end
        repeat (3) idle();
        @(negedge clk_i); #2;
        check("drain_rsp", 32'(rsp_q.size()), 32'h0);
        check("drain_gnt", 32'(gnt_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
